// File: rtl/pc_fetch_seq.sv
// rtl/pc_fetch_seq.sv - byte-serial Y86-64 instruction fetch sequencer (IDLE/FETCH/DONE)
// Optional FETCH_BOUNDS_CHECK_EN: addresses at or beyond IMEM_BYTES end the fetch with imem_error.
module pc_fetch_seq #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] PC_new,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_data,
  input  logic        imem_err,
  output logic [63:0] PC,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        instr_valid,
  output logic        busy,
  output logic        imem_error,
  output logic        instr_invalid
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_boot;
  logic [63:0] r_pc, r_valc, r_valp;
  logic [3:0]  r_idx, r_len, r_icode, r_ifun, r_ra, r_rb;
  logic        r_err, r_inv;

  logic [63:0] w_addr;
  logic        w_oob, w_req, w_ack, w_last, w_load;
  logic [3:0]  w_len0, w_cur_len;
  logic [2:0]  w_off;
  logic [5:0]  w_sh;

  function automatic logic [3:0] f_len(input logic [3:0] hi);
    case (hi)
      4'h0, 4'h1, 4'h9:       f_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: f_len = 4'd2;
      4'h7, 4'h8:             f_len = 4'd9;
      4'h3, 4'h4, 4'h5:       f_len = 4'd10;
      default:                f_len = 4'd1;
    endcase
  endfunction

  assign w_addr = r_pc + {60'b0, r_idx};

`ifdef FETCH_BOUNDS_CHECK_EN
  assign w_oob = (w_addr >= 64'(IMEM_BYTES));
`else
  // Never true for a legal configuration; the memory size is irrelevant here.
  assign w_oob = (IMEM_BYTES < 0);
`endif

  assign w_req     = (r_state == S_FETCH) && !w_oob;
  assign w_ack     = w_req && imem_ack;
  assign w_len0    = f_len(imem_data[7:4]);
  assign w_cur_len = (r_idx == 4'd0) ? w_len0 : r_len;
  assign w_last    = w_ack && (imem_err || (r_idx == w_cur_len - 4'd1));
  assign w_load    = start && (r_state != S_FETCH);
  // valC byte lane: immediates start at byte 1 (length 9) or byte 2 (length 10)
  assign w_off     = 3'(r_idx - ((r_len == 4'd9) ? 4'd1 : 4'd2));
  assign w_sh      = {w_off, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_boot || start) w_next = S_FETCH;
      S_FETCH: if (w_oob || w_last) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_FETCH;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_boot  <= 1'b1;
      r_pc    <= RESET_PC;
      r_idx   <= 4'd0;
      r_len   <= 4'd1;
      r_icode <= 4'h0;
      r_ifun  <= 4'h0;
      r_ra    <= 4'hF;
      r_rb    <= 4'hF;
      r_valc  <= 64'd0;
      r_valp  <= 64'd0;
      r_err   <= 1'b0;
      r_inv   <= 1'b0;
    end else begin
      r_boot <= 1'b0;
      if (w_load) begin
        r_pc    <= PC_new;
        r_idx   <= 4'd0;
        r_icode <= 4'h0;
        r_ifun  <= 4'h0;
        r_ra    <= 4'hF;
        r_rb    <= 4'hF;
        r_valc  <= 64'd0;
        r_valp  <= 64'd0;
        r_err   <= 1'b0;
        r_inv   <= 1'b0;
      end else if (r_state == S_FETCH) begin
        if (w_oob) begin
          r_err <= 1'b1;
        end else if (w_ack) begin
          if (imem_err) begin
            r_err <= 1'b1;
          end else begin
            r_idx <= r_idx + 4'd1;
            if (r_idx == 4'd0) begin
              r_icode <= imem_data[7:4];
              r_ifun  <= imem_data[3:0];
              r_len   <= w_len0;
              r_valp  <= r_pc + {60'b0, w_len0};
              r_inv   <= (imem_data[7:4] >= 4'hC);
            end else if (r_idx == 4'd1 && (r_len == 4'd2 || r_len == 4'd10)) begin
              r_ra <= imem_data[7:4];
              r_rb <= imem_data[3:0];
            end else begin
              r_valc[w_sh +: 8] <= imem_data;
            end
          end
        end
      end
    end
  end

  assign imem_req      = w_req;
  assign imem_addr     = w_addr;
  assign PC            = r_pc;
  assign icode         = r_icode;
  assign ifun          = r_ifun;
  assign rA            = r_ra;
  assign rB            = r_rb;
  assign valC          = r_valc;
  assign valP          = r_valp;
  assign instr_valid   = (r_state == S_DONE);
  assign busy          = (r_state == S_FETCH);
  assign imem_error    = r_err;
  assign instr_invalid = r_inv;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// tb/tb_pc_fetch_seq.sv - self-checking bench for pc_fetch_seq (vector table, random vs model, corner sequences)
module tb_pc_fetch_seq;

  localparam int IMEM = 64;
`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDED = 1'b1;
  localparam int NV = 5;
`else
  localparam bit BOUNDED = 1'b0;
  localparam int NV = 6;
`endif

  logic        clk = 1'b0;
  logic        rst, start, imem_ack, imem_err;
  logic [63:0] PC_new;
  logic [7:0]  imem_data;
  logic        imem_req, instr_valid, busy, imem_error, instr_invalid;
  logic [63:0] imem_addr, PC, valC, valP;
  logic [3:0]  icode, ifun, rA, rB;

  pc_fetch_seq #(.RESET_PC(64'h0), .IMEM_BYTES(IMEM)) dut (
    .clk(clk), .rst(rst), .start(start), .PC_new(PC_new),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .imem_err(imem_err),
    .PC(PC), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .instr_valid(instr_valid), .busy(busy), .imem_error(imem_error), .instr_invalid(instr_invalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic        inv;
    logic        err;
    logic [3:0]  nacks;
  } exp_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [79:0] bytes;
    logic [1:0]  dly;
    logic        poke;
    exp_t        e;
  } vec_t;

  logic [7:0]  mem [0:255];
  int          delay = 0;
  int          wcnt = 0;
  logic        err_en = 1'b0;
  logic [63:0] err_addr = '0;
  logic [63:0] acks [$];
  int          n_pass = 0;
  int          n_total = 0;
  vec_t        vecs [NV];

  // Byte-wide memory responder: ack after `delay` waiting cycles, log every acked address
  always @(negedge clk) begin
    if (!rst && imem_req && wcnt >= delay) begin
      imem_ack  = 1'b1;
      imem_data = mem[imem_addr[7:0]];
      imem_err  = err_en && (imem_addr == err_addr);
      acks.push_back(imem_addr);
      wcnt = 0;
    end else begin
      imem_ack  = 1'b0;
      imem_err  = 1'b0;
      imem_data = 8'h00;
      if (!rst && imem_req) wcnt = wcnt + 1;
      else wcnt = 0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [7:0] mb(input logic [63:0] a);
    return mem[a[7:0]];
  endfunction

  function automatic int len_of(input logic [3:0] hi);
    if (hi == 4'h0 || hi == 4'h1 || hi == 4'h9) return 1;
    if (hi == 4'h2 || hi == 4'h6 || hi == 4'hA || hi == 4'hB) return 2;
    if (hi == 4'h7 || hi == 4'h8) return 9;
    if (hi >= 4'h3 && hi <= 4'h5) return 10;
    return 1;
  endfunction

  task automatic model(input logic [63:0] pc, input bit eerr, input int eidx, output exp_t e);
    logic [7:0]  b0, b1;
    logic [63:0] a;
    int len, base;
    b0 = mb(pc);
    len = len_of(b0[7:4]);
    e = '0;
    e.icode = b0[7:4];
    e.ifun  = b0[3:0];
    e.ra    = 4'hF;
    e.rb    = 4'hF;
    e.inv   = (b0[7:4] >= 4'hC);
    e.valp  = pc + 64'(len);
    for (int i = 0; i < len; i++) begin
      a = pc + 64'(i);
      if (BOUNDED && a >= 64'(IMEM)) begin e.err = 1'b1; break; end
      e.nacks = e.nacks + 4'd1;
      if (eerr && i == eidx) begin e.err = 1'b1; break; end
    end
    if (len == 2 || len == 10) begin
      b1 = mb(pc + 64'd1);
      e.ra = b1[7:4];
      e.rb = b1[3:0];
    end
    base = (len == 10) ? 2 : (len == 9) ? 1 : 0;
    if (base != 0)
      for (int k = 0; k < 8; k++) e.valc[8*k +: 8] = mb(pc + 64'(base + k));
  endtask

  task automatic do_fetch(input logic [63:0] pc, input int dly, input bit poke, output int cyc);
    acks.delete();
    delay = dly;
    @(negedge clk);
    start = 1'b1;
    PC_new = pc;
    @(posedge clk); #1;
    start = 1'b0;
    PC_new = '0;
    cyc = 1;
    while (!instr_valid && cyc < 400) begin
      @(posedge clk); #1;
      cyc = cyc + 1;
      if (poke && cyc == 3) begin start = 1'b1; PC_new = 64'hDEAD_BEEF; end
      else start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic check_out(input string nm, input logic [63:0] pc, input exp_t e);
    int bad;
    bad = 0;
    for (int i = 0; i < acks.size(); i++) if (acks[i] !== pc + 64'(i)) bad = bad + 1;
    chk({nm, ".valid"}, 64'(instr_valid), 64'd1);
    chk({nm, ".err"}, 64'(imem_error), 64'(e.err));
    chk({nm, ".pc"}, PC, pc);
    chk({nm, ".nacks"}, 64'(acks.size()), 64'(e.nacks));
    chk({nm, ".addrs"}, 64'(bad), 64'd0);
    if (!e.err) begin
      chk({nm, ".icode"}, 64'(icode), 64'(e.icode));
      chk({nm, ".ifun"}, 64'(ifun), 64'(e.ifun));
      chk({nm, ".rA"}, 64'(rA), 64'(e.ra));
      chk({nm, ".rB"}, 64'(rB), 64'(e.rb));
      chk({nm, ".valC"}, valC, e.valc);
      chk({nm, ".valP"}, valP, e.valp);
      chk({nm, ".invalid"}, 64'(instr_invalid), 64'(e.inv));
    end
  endtask

  task automatic put_bytes(input logic [63:0] pc, input logic [79:0] b);
    logic [63:0] a;
    for (int k = 0; k < 10; k++) begin
      a = pc + 64'(k);
      mem[a[7:0]] = b[8*k +: 8];
    end
  endtask

  initial begin
    int   cyc;
    exp_t e;
    logic [63:0] pc;
    bit   eerr;
    int   eidx;

    vecs[0] = '{pc:64'h10, bytes:80'h00000000000000_0AF230, dly:2'd0, poke:1'b0,
                e:'{icode:4'h3, ifun:4'h0, ra:4'hF, rb:4'h2, valc:64'hA, valp:64'h1A, inv:1'b0, err:1'b0, nacks:4'd10}};
    vecs[1] = '{pc:64'h20, bytes:80'h0000000000000000_4073, dly:2'd2, poke:1'b1,
                e:'{icode:4'h7, ifun:4'h3, ra:4'hF, rb:4'hF, valc:64'h40, valp:64'h29, inv:1'b0, err:1'b0, nacks:4'd9}};
    vecs[2] = '{pc:64'h30, bytes:80'hC0, dly:2'd0, poke:1'b0,
                e:'{icode:4'hC, ifun:4'h0, ra:4'hF, rb:4'hF, valc:64'h0, valp:64'h31, inv:1'b1, err:1'b0, nacks:4'd1}};
    vecs[3] = '{pc:64'h34, bytes:80'h1260, dly:2'd1, poke:1'b0,
                e:'{icode:4'h6, ifun:4'h0, ra:4'h1, rb:4'h2, valc:64'h0, valp:64'h36, inv:1'b0, err:1'b0, nacks:4'd2}};
    vecs[4] = '{pc:64'h38, bytes:80'h10, dly:2'd0, poke:1'b0,
                e:'{icode:4'h1, ifun:4'h0, ra:4'hF, rb:4'hF, valc:64'h0, valp:64'h39, inv:1'b0, err:1'b0, nacks:4'd1}};
`ifndef FETCH_BOUNDS_CHECK_EN
    vecs[5] = '{pc:64'hFFFF_FFFF_FFFF_FFFE, bytes:80'hAB20, dly:2'd0, poke:1'b0,
                e:'{icode:4'h2, ifun:4'h0, ra:4'hA, rb:4'hB, valc:64'h0, valp:64'h0, inv:1'b0, err:1'b0, nacks:4'd2}};
`endif

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b1; start = 1'b0; PC_new = '0;
    imem_ack = 1'b0; imem_err = 1'b0; imem_data = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.req", 64'(imem_req), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.valid", 64'(instr_valid), 64'd0);
    chk("rst.pc", PC, 64'h0);
    chk("rst.icode_ifun", {56'd0, icode, ifun}, 64'h00);
    chk("rst.rArB", {56'd0, rA, rB}, 64'hFF);
    chk("rst.valC", valC, 64'd0);
    chk("rst.valP", valP, 64'd0);
    chk("rst.flags", {62'd0, imem_error, instr_invalid}, 64'd0);

    // boot fetch straight out of reset
    acks.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("boot.busy", 64'(busy), 64'd1);
    cyc = 0;
    while (!instr_valid && cyc < 50) begin @(posedge clk); #1; cyc = cyc + 1; end
    check_out("boot", 64'h0, '{icode:4'h0, ifun:4'h0, ra:4'hF, rb:4'hF, valc:64'h0, valp:64'h1,
                              inv:1'b0, err:1'b0, nacks:4'd1});

    for (int i = 0; i < NV; i++) begin
      put_bytes(vecs[i].pc, vecs[i].bytes);
      err_en = 1'b0;
      do_fetch(vecs[i].pc, int'(vecs[i].dly), vecs[i].poke, cyc);
      check_out($sformatf("vec%0d", i), vecs[i].pc, vecs[i].e);
      if (vecs[i].dly == 2'd0) chk($sformatf("vec%0d.latency", i), 64'(cyc), 64'(vecs[i].e.nacks) + 64'd1);
    end

    // memory error on the third byte of an irmovq
    put_bytes(64'h10, 80'h00000000000000_0AF230);
    err_en = 1'b1;
    err_addr = 64'h12;
    do_fetch(64'h10, 0, 1'b0, cyc);
    chk("merr.err", 64'(imem_error), 64'd1);
    chk("merr.nacks", 64'(acks.size()), 64'd3);
    err_en = 1'b0;

    // irmovq straddling the end of a 64-byte memory
    put_bytes(64'h3C, 80'h00000000000000_0AF230);
    do_fetch(64'h3C, 0, 1'b0, cyc);
    chk("bound.nacks", 64'(acks.size()), BOUNDED ? 64'd4 : 64'd10);
    chk("bound.err", 64'(imem_error), BOUNDED ? 64'd1 : 64'd0);
    chk("bound.valid", 64'(instr_valid), 64'd1);

    for (int it = 0; it < 40; it++) begin
      pc = 64'($urandom_range(0, 50));
      put_bytes(pc, {$urandom(), $urandom(), 16'($urandom())});
      eerr = ($urandom_range(0, 4) == 0);
      eidx = $urandom_range(0, 9);
      err_en = eerr;
      err_addr = pc + 64'(eidx);
      model(pc, eerr, eidx, e);
      do_fetch(pc, $urandom_range(0, 2), 1'b0, cyc);
      check_out($sformatf("rnd%0d", it), pc, e);
    end
    err_en = 1'b0;

    // reset in the middle of an irmovq fetch
    put_bytes(64'h10, 80'h00000000000000_0AF230);
    delay = 1;
    @(negedge clk);
    start = 1'b1; PC_new = 64'h10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst.req", 64'(imem_req), 64'd0);
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.pc", PC, 64'h0);
    mem[0] = 8'h10;
    repeat (2) @(negedge clk);
    acks.delete();
    rst = 1'b0;
    cyc = 0;
    while (!instr_valid && cyc < 50) begin @(posedge clk); #1; cyc = cyc + 1; end
    check_out("midrst", 64'h0, '{icode:4'h1, ifun:4'h0, ra:4'hF, rb:4'hF, valc:64'h0, valp:64'h1,
                                inv:1'b0, err:1'b0, nacks:4'd1});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
